// File: rtl/epw22_result_capture.sv
// epw22_result_capture: time-stamped, ordered result collector for the EPW22 design.
//
// Samples every result retired on in_valid (while in RUN), tags it with a free-running
// cycle stamp and queues it in a DEPTH-entry FIFO read out over a valid/ready port.
// A result arriving while the FIFO is full (with no pop that cycle) is dropped, sets the
// sticky overflow flag, bumps drop_count (saturating) and parks the block in HALT.
//
// Optional feature: define EPW22_CAPTURE_STAMP_EN to build the stamp counter and per-entry
// stamp storage; with it undefined out_stamp is tied to 0.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, clear                    control pulses (clear wins over everything)
//   in_valid, in_opcode, in_result  retired-result input
//   out_valid, out_ready            head-of-FIFO handshake
//   out_opcode, out_result, out_stamp  head entry (held when the FIFO is empty)
//   overflow, drop_count            loss reporting
//   state                           IDLE=0, RUN=1, HALT=2
module epw22_result_capture #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STAMP_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [OP_W-1:0]    in_opcode,
  input  logic [DATA_W-1:0]  in_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_opcode,
  output logic [DATA_W-1:0]  out_result,
  output logic [STAMP_W-1:0] out_stamp,
  output logic               overflow,
  output logic [7:0]         drop_count,
  output logic [1:0]         state
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic [OP_W-1:0]   last_op_q, last_op_d;
  logic [DATA_W-1:0] last_res_q, last_res_d;

  logic [OP_W-1:0]   op_mem_q  [DEPTH];
  logic [DATA_W-1:0] res_mem_q [DEPTH];

  logic empty, full, push, pop, drop;
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  // Extra pointer MSB differs only when the writer has lapped the reader.
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (!clear) begin
      pop = !empty && out_ready;
      if (state_q == StRun && in_valid) begin
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        if (!full || pop) push = 1'b1;
        else              drop = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear) begin
      state_d      = StIdle;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (drop) begin
        overflow_d = 1'b1;
        state_d    = StHalt;
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end
      if (state_q == StIdle && start) state_d = StRun;
    end
  end

  // Head data is read straight from storage; the last shown value is kept so the
  // outputs hold steady once the FIFO runs empty.
  always_comb begin
    out_valid  = !empty;
    out_opcode = empty ? last_op_q  : op_mem_q[rd_idx];
    out_result = empty ? last_res_q : res_mem_q[rd_idx];
    last_op_d  = out_opcode;
    last_res_d = out_result;
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      last_op_q    <= '0;
      last_res_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      last_op_q    <= last_op_d;
      last_res_q   <= last_res_d;
    end
  end

  // Storage needs no reset: it is only visible through out_* while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_idx]  <= in_opcode;
      res_mem_q[wr_idx] <= in_result;
    end
  end

`ifdef EPW22_CAPTURE_STAMP_EN
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [STAMP_W-1:0] last_stamp_q, last_stamp_d;
  logic [STAMP_W-1:0] stamp_mem_q [DEPTH];

  // Free-running in every state, untouched by clear; wraps naturally.
  assign stamp_d = stamp_q + 1'b1;

  always_comb begin
    out_stamp    = empty ? last_stamp_q : stamp_mem_q[rd_idx];
    last_stamp_d = out_stamp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp_q      <= '0;
      last_stamp_q <= '0;
    end else begin
      stamp_q      <= stamp_d;
      last_stamp_q <= last_stamp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stamp_mem_q[wr_idx] <= stamp_q;
  end
`else
  assign out_stamp = '0;
`endif

endmodule

// File: tb/tb_epw22_result_capture.sv
// Self-checking bench for epw22_result_capture: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a queue model.
module tb_epw22_result_capture;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_opcode = '0;
  logic [31:0] in_result = '0;
  logic        out_valid, overflow;
  logic [3:0]  out_opcode;
  logic [31:0] out_result;
  logic [SW-1:0] out_stamp;
  logic [7:0]  drop_count;
  logic [1:0]  state;

  epw22_result_capture #(
    .DATA_W (32),
    .OP_W   (4),
    .DEPTH  (DEPTH),
    .STAMP_W(SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_opcode (in_opcode),
    .in_result (in_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_opcode(out_opcode),
    .out_result(out_result),
    .out_stamp (out_stamp),
    .overflow  (overflow),
    .drop_count(drop_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] res;
    int          stamp;
  } ent_t;

  ent_t        mq[$];
  int          m_state, m_drop, m_cnt;
  bit          m_ovf;
  logic [3:0]  last_op;
  logic [31:0] last_res;
  int          last_stamp;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_drop = 0; m_cnt = 0; m_ovf = 0;
    last_op = '0; last_res = '0; last_stamp = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    ent_t e;
    bit   cap;
    if (clear) begin
      mq.delete();
      m_ovf = 0; m_drop = 0; m_state = 0;
    end else begin
      cap = (m_state == 1) && in_valid;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) begin
          e.op = in_opcode; e.res = in_result; e.stamp = m_cnt;
          mq.push_back(e);
        end else begin
          if (m_drop < 255) m_drop++;
          m_ovf = 1; m_state = 2;
        end
      end
      if (m_state == 0 && start) m_state = 1;
    end
    m_cnt = (m_cnt + 1) % (1 << SW);
  endtask

  task automatic check_all();
    logic        e_valid;
    logic [3:0]  e_op;
    logic [31:0] e_res;
    int          e_stamp;
    e_valid = (mq.size() > 0);
    e_op    = e_valid ? mq[0].op  : last_op;
    e_res   = e_valid ? mq[0].res : last_res;
    e_stamp = e_valid ? mq[0].stamp : last_stamp;
`ifndef EPW22_CAPTURE_STAMP_EN
    e_stamp = 0;
`endif
    chk("out_valid",  32'(out_valid),  32'(e_valid));
    chk("out_opcode", 32'(out_opcode), 32'(e_op));
    chk("out_result", out_result,      e_res);
    chk("out_stamp",  32'(out_stamp),  32'(e_stamp));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("state",      32'(state),      32'(m_state));
    last_op = e_op; last_res = e_res; last_stamp = e_stamp;
  endtask

  // One cycle: drive at negedge, step the model, clock, compare at the next negedge.
  task automatic cyc(input logic st, input logic cl, input logic iv, input logic [3:0] op,
                     input logic [31:0] res, input logic rdy);
    start = st; clear = cl; in_valid = iv; in_opcode = op; in_result = res; out_ready = rdy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_op",    32'(out_opcode), 0);
    chk("rst_res",   out_result, 0);
    chk("rst_stamp", 32'(out_stamp), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_drop",  32'(drop_count), 0);
    chk("rst_state", 32'(state), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    bit seen15;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Idle: in_valid ignored.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'h5, 32'h1111 + i, 0);
    chk("idle_no_capture", 32'(out_valid), 0);

    // Mid-stream async reset.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'(i), 32'h50 + i, 0);
    do_reset();

    // Single capture.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 4'h3, 32'hDEAD_BEEF, 0);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_op",    32'(out_opcode), 32'h3);
    chk("single_res",   out_result, 32'hDEAD_BEEF);
    cyc(0, 0, 0, 0, 0, 1);

    // Overflow: 9 results with the reader stalled.
    for (int i = 1; i <= 9; i++) cyc(0, 0, 1, 4'(i), 32'(i), 0);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_drop",  32'(drop_count), 1);
    chk("ovf_state", 32'(state), 2);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 4'hF, 32'hBAD, 0);
    chk("halt_drop_hold", 32'(drop_count), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", out_result, 32'(i));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("drain_empty", 32'(out_valid), 0);

    // Full with simultaneous pop.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 4'h1, 32'(100 + i), 0);
    cyc(0, 0, 1, 4'h2, 32'd200, 1);
    chk("fullpop_drop",  32'(drop_count), 0);
    chk("fullpop_state", 32'(state), 1);
    for (int i = 0; i < 8; i++) begin
      chk("fullpop_order", out_result, (i < 7) ? 32'(102 + i) : 32'd200);
      cyc(0, 0, 0, 0, 0, 1);
    end

    // Clear priority from HALT holding 3 entries.
    for (int i = 1; i <= 9; i++) cyc(0, 0, 1, 4'h7, 32'(300 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("halt3_state", 32'(state), 2);
    cyc(1, 1, 1, 4'h9, 32'h999, 1);
    chk("clr_state", 32'(state), 0);
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_ovf",   32'(overflow), 0);
    chk("clr_drop",  32'(drop_count), 0);

    // Start with in_valid while IDLE: that result is not captured.
    cyc(1, 0, 1, 4'hA, 32'hAAAA, 0);
    chk("start_iv_nocap", 32'(out_valid), 0);

    // Streaming with reader always ready: stamps must walk through the wrap.
    seen15 = 0;
    for (int i = 0; i < 20; i++) begin
`ifdef EPW22_CAPTURE_STAMP_EN
      if (seen15) begin
        chk("stamp_wrap", 32'(out_stamp), 0);
        seen15 = 0;
      end else if (out_valid && out_stamp == 4'hF) seen15 = 1;
`else
      chk("stamp_tied0", 32'(out_stamp), 0);
`endif
      cyc(0, 0, 1, 4'(i), 32'(1000 + i), 1);
    end
    chk("stream_no_drop", 32'(drop_count), 0);
    cyc(0, 1, 0, 0, 0, 0);

    // Randomized phase; reader eagerness varies by epoch to reach overflow and drain.
    for (int ep = 0; ep < 12; ep++) begin
      int rmod;
      rmod = 1 + (ep % 4);
      for (int i = 0; i < 200; i++) begin
        cyc(($urandom % 12) == 0, ($urandom % 90) == 0, ($urandom % 3) != 0,
            4'($urandom), $urandom, ($urandom % rmod) == 0);
      end
      if (ep == 6) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/epw22_result_capture.md
# epw22_result_capture

Synthesizable result collector on the output side of the EPW22 design. Samples every result the design retires on its result handshake and time-stamps it with a cycle counter. Results are buffered in a small FIFO and presented to the scoreboard-side reader over a valid/ready port. It replaces sampling of raw design outputs with an ordered, lossless (or loss-flagged) result stream.

## Interface

**Parameters**

- DATA_W, 32, result data width
- OP_W, 4, opcode width carried with each result
- DEPTH, 8, FIFO entries; power of 2, minimum 2
- STAMP_W, 16, cycle-stamp width

**Ports**

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; IDLE -> RUN
- clear  in  1  pulse; flushes FIFO, clears overflow and drop count, goes to IDLE
- in_valid  in  1  design presents a retired result this cycle
- in_opcode  in  OP_W  opcode of the result
- in_result  in  DATA_W  result value
- out_valid  out  1  head entry available
- out_ready  in  1  reader accepts head entry
- out_opcode  out  OP_W  head opcode
- out_result  out  DATA_W  head result
- out_stamp  out  STAMP_W  cycle stamp of head entry
- overflow  out  1  sticky; a result arrived while the FIFO was full
- drop_count  out  8  number of dropped results; saturates at 255
- state  out  2  IDLE=0, RUN=1, HALT=2

## Operation

- **Reset:** all outputs 0; state IDLE; FIFO empty; stamp counter 0.
- **Stamp counter:** free-running from reset in every state. Increments each cycle. Wraps from 2^STAMP_W-1 to 0.
- **IDLE:** in_valid ignored; FIFO may still be drained. `start` -> RUN.
- **RUN:** on each cycle with in_valid=1:
  - If not full, or full with a pop this same cycle: push {in_opcode, in_result, current stamp}.
  - Otherwise the result is dropped: drop_count += 1 (saturating), overflow set, state -> HALT.
- **HALT:** captures nothing further; the FIFO drains normally. Only `clear` or reset leaves HALT. `start` is ignored in HALT.
- **clear:** has priority over start, push and pop in the same cycle. Resets FIFO pointers, overflow and drop_count, and sets state to IDLE. The stamp counter is not reset by clear.
- **Pop:** occurs when out_valid && out_ready. out_ready while empty has no effect.
- **Empty FIFO:** out_valid=0, and out_opcode/out_result/out_stamp hold their last-driven values (0 after reset).
- **Ordering:** strictly FIFO; no reordering and no duplicate entries.
- **Full/empty tracking:** read and write pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.

## Timing

- **Latency:** a result sampled on edge N appears as out_valid=1 with its data after edge N. The stamp equals the counter value at edge N.
- **Back-to-back:** in_valid may be high every cycle. With out_ready held high, throughput is one result per cycle with no loss.
- **Simultaneous push and pop on empty:** the pushed entry becomes head after the edge; the pop has no effect.
- **Simultaneous push and pop on full:** both occur; the count stays at DEPTH and no drop is recorded.
- **start and in_valid in the same cycle while IDLE:** that in_valid is not captured. Capture begins the following cycle.
- **Async reset mid-stream:** outputs go to reset values immediately and FIFO contents are discarded.

## Configuration

- **EPW22_CAPTURE_STAMP_EN defined:** stamp counter and per-entry stamp storage are present, as described above.
- **Undefined:** no counter and no stamp storage; out_stamp is tied to 0. All other behaviour is identical.

## Test plan

- **Reset and idle:** assert rst_n=0 mid-run, then release. All outputs are 0 and state=0. in_valid pulses while IDLE produce out_valid=0.
- **Single capture:** start, then one cycle later in_valid with op=4'h3, result=32'hDEAD_BEEF. out_valid rises one cycle later with those values. out_stamp equals the counter value at the capture edge; the difference from a reference counter is 0.
- **Overflow:** DEPTH=8, out_ready=0, 9 consecutive in_valid. Entries 1-8 are stored, then overflow=1, drop_count=1, state=HALT. Later in_valid pulses are ignored (drop_count stays 1). Draining returns entries 1-8 in order.
- **Full with simultaneous pop:** fill 8 entries, then assert in_valid and out_ready together. No drop, count stays 8, and the new entry is last in drain order.
- **clear priority:** in HALT with 3 entries, assert clear, start and in_valid in the same cycle. Result is state=IDLE, out_valid=0, overflow=0, drop_count=0.
- **Stamp wrap (macro defined, STAMP_W=4):** capture at counter values 15 and 0 on consecutive cycles. out_stamp reads 15 then 0. With the macro undefined, out_stamp is always 0.
